alu_mc: RTL

- Parametrised multi-cycle successor to the single-cycle execute-stage ALU of the pipelined CPU.
- Single-cycle ops: ADD, SUB, AND, ORR, MUL.
- Adds iterative unsigned divide/remainder, replacing the combinational divider, so the execute stage no longer carries a WIDTH-bit combinational divide path.
- The hazard unit uses a start/busy/done handshake to stall the pipeline while a divide is in flight.

---
 rtl/alu_mc_pkg.sv | 37 +++
 rtl/alu_divider.sv | 71 +++++++
 rtl/alu_mc.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: opcodes, FSM states, flag bit positions.
package alu_mc_pkg;

  // 3'b111 is SDIV when ALU_MC_SIGNED_DIV_EN is defined, otherwise a reserved op yielding zero.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_UDIV = 3'b011,
    OP_AND  = 3'b100,
    OP_ORR  = 3'b101,
    OP_UREM = 3'b110,
    OP_SDIV = 3'b111
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] mk_flags(input logic n, input logic z, input logic c,
                                          input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, WIDTH steps after load.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    // A negative trial restores; a restored value is below the divisor so its top bit is zero.
    rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      rem_d = rem_nx;
      quo_d = quo_nx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs are the post-step values, so the owner can register them on the final step's edge.
  assign quotient  = quo_nx;
  assign remainder = rem_nx;
  assign valid     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with start/busy/done handshake and iterative divide.
// Define ALU_MC_SIGNED_DIV_EN to turn opcode 111 into a signed divide (SDIV).
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             busy,
  output logic             done,
  output logic             divzero
);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;
  logic             bzero_q, bzero_d;

  alu_op_e          op_in;
  logic             is_div_in;
  logic             div_load;
  logic [WIDTH-1:0] div_dividend, div_divisor;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_valid;

  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] short_res;
  logic             short_c, short_v;
  logic [WIDTH-1:0] fin_res;
  logic             fin_v;

  assign op_in = alu_op_e'(ALUControl);

`ifdef ALU_MC_SIGNED_DIV_EN
  logic neg_q, neg_d;
  logic ovf_q, ovf_d;

  assign is_div_in    = (op_in == OP_UDIV) || (op_in == OP_UREM) || (op_in == OP_SDIV);
  // SDIV runs on magnitudes; the sign is reapplied to the quotient at completion.
  assign div_dividend = (op_in == OP_SDIV && a[WIDTH-1]) ? -a : a;
  assign div_divisor  = (op_in == OP_SDIV && b[WIDTH-1]) ? -b : b;
`else
  assign is_div_in    = (op_in == OP_UDIV) || (op_in == OP_UREM);
  assign div_dividend = a;
  assign div_divisor  = b;
`endif

  assign div_load = start && (state_q == IDLE) && is_div_in;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Single-cycle datapath.
  always_comb begin
    sub      = (op_in == OP_SUB);
    bx       = sub ? ~b : b;
    sum_full = {1'b0, a} + {1'b0, bx} + (WIDTH + 1)'(sub);
    short_c  = 1'b0;
    short_v  = 1'b0;
    case (op_in)
      OP_ADD, OP_SUB: begin
        short_res = sum_full[WIDTH-1:0];
        short_c   = sum_full[WIDTH];
        short_v   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum_full[WIDTH-1]);
      end
      OP_MUL:  short_res = a * b;
      OP_AND:  short_res = a & b;
      OP_ORR:  short_res = a | b;
      default: short_res = '0;
    endcase
  end

  // Divide completion value.
  always_comb begin
    fin_res = (op_q == OP_UREM) ? div_rem : div_quo;
    fin_v   = 1'b0;
`ifdef ALU_MC_SIGNED_DIV_EN
    if (op_q == OP_SDIV) begin
      if (bzero_q)    fin_res = '1;
      else if (neg_q) fin_res = -div_quo;
      else            fin_res = div_quo;
      fin_v = ovf_q;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    result_d  = result_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    divzero_d = divzero_q;
    bzero_d   = bzero_q;
`ifdef ALU_MC_SIGNED_DIV_EN
    neg_d     = neg_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = op_in;
          divzero_d = 1'b0;
          if (is_div_in) begin
            state_d = DIV;
            bzero_d = (b == '0);
`ifdef ALU_MC_SIGNED_DIV_EN
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            ovf_d   = (op_in == OP_SDIV) && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
`endif
          end else begin
            result_d = short_res;
            flags_d  = mk_flags(short_res[WIDTH-1], short_res == '0, short_c, short_v);
            done_d   = 1'b1;
          end
        end
      end
      DIV: begin
        if (div_valid) begin
          state_d   = IDLE;
          result_d  = fin_res;
          flags_d   = mk_flags(fin_res[WIDTH-1], fin_res == '0, 1'b0, fin_v);
          done_d    = 1'b1;
          divzero_d = bzero_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      bzero_q   <= 1'b0;
`ifdef ALU_MC_SIGNED_DIV_EN
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
      bzero_q   <= bzero_d;
`ifdef ALU_MC_SIGNED_DIV_EN
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign Result  = result_q;
  assign Flags   = flags_q;
  assign busy    = (state_q == DIV);
  assign done    = done_q;
  assign divzero = divzero_q;

endmodule
